// File: rtl/crg_pkg.sv
// Shared types and defaults for the CRG clock-gate control block.
package crg_pkg;

   // Gate controller states
   typedef enum logic [2:0] {
      RUN      = 3'd0,
      IDLE_CNT = 3'd1,
      STOP_REQ = 3'd2,
      GATED    = 3'd3,
      WAKE     = 3'd4
   } cg_state_e;

   localparam int CG_IDLE_CYCLES_DEF = 16;
   localparam int CG_WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/clock_gate_ctrl.sv
// Clock-gate controller: stops a downstream domain's clock after a long
// enough idle period plus a stop handshake, and restarts it on wake/force-on
// with a settle period before the domain is released. All outputs registered.
module clock_gate_ctrl
   import crg_pkg::*;
#(
   parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
   parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic BUSY_I,
   input  logic WAKE_REQ_I,
   input  logic FORCE_ON_I,
   input  logic STOP_ACK_I,
   output logic STOP_REQ_O,
   output logic EN_O,
   output logic GATED_O,
   output logic WAKE_DONE_O
);

   localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Zero-length idle or wake windows make the handshake meaningless
   if (IDLE_CYCLES < 1) begin : g_bad_idle
      $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
   end
   if (WAKE_CYCLES < 1) begin : g_bad_wake
      $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
   end

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   cg_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             req_nxt, en_nxt, gated_nxt, done_nxt;
   logic             wake;

   assign wake = WAKE_REQ_I | FORCE_ON_I;

   // State, counter and registered outputs; reset lands in RUN with clock on
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= RUN;
         cnt         <= '0;
         STOP_REQ_O  <= 1'b0;
         EN_O        <= 1'b1;
         GATED_O     <= 1'b0;
         WAKE_DONE_O <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         STOP_REQ_O  <= req_nxt;
         EN_O        <= en_nxt;
         GATED_O     <= gated_nxt;
         WAKE_DONE_O <= done_nxt;
      end
   end

   // Next-state and next-output decode; outputs hold unless a transition edits them
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = STOP_REQ_O;
      en_nxt    = EN_O;
      gated_nxt = GATED_O;
      done_nxt  = 1'b0;
      case (state)
         RUN: begin
            if (!BUSY_I && !wake) begin
               state_nxt = IDLE_CNT;
               cnt_nxt   = CNT_ONE;
            end
         end
         IDLE_CNT: begin
            if (BUSY_I || wake) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else if (cnt == IDLE_LAST) begin
               state_nxt = STOP_REQ;
               req_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         STOP_REQ: begin
            // Renewed activity beats a same-cycle acknowledge: the clock never drops
            if (wake || BUSY_I) begin
               state_nxt = RUN;
               req_nxt   = 1'b0;
               cnt_nxt   = '0;
            end else if (STOP_ACK_I) begin
               state_nxt = GATED;
               en_nxt    = 1'b0;
               gated_nxt = 1'b1;
            end
         end
         GATED: begin
            // Domain is frozen, so only wake matters; ack dropping is ignored
            if (wake) begin
               state_nxt = WAKE;
               en_nxt    = 1'b1;
               gated_nxt = 1'b0;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAKE: begin
            // Settle window runs to completion even if wake drops
            if (cnt == WAKE_LAST) begin
               state_nxt = RUN;
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            req_nxt   = 1'b0;
            en_nxt    = 1'b1;
            gated_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed vector bench for clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clock_gate_ctrl;

   logic clk = 1'b0;
   logic rst, busy, wake_req, force_on, stop_ack;
   logic stop_req, en, gated, wake_done;

   int n_vec = 0;
   int n_err = 0;

   // Inputs for one edge and the outputs expected just after it
   typedef struct {
      logic       rst, busy, wake, frc, ack;
      logic [3:0] exp;   // {stop_req, en, gated, wake_done}
      string      name;
   } vec_t;

   vec_t tbl[$];

   clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
      .CLK        (clk),
      .RST        (rst),
      .BUSY_I     (busy),
      .WAKE_REQ_I (wake_req),
      .FORCE_ON_I (force_on),
      .STOP_ACK_I (stop_ack),
      .STOP_REQ_O (stop_req),
      .EN_O       (en),
      .GATED_O    (gated),
      .WAKE_DONE_O(wake_done)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, b, w, f, a, input logic [3:0] e, input string nm);
      vec_t v;
      v.rst = r; v.busy = b; v.wake = w; v.frc = f; v.ack = a; v.exp = e; v.name = nm;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      logic [3:0] act;
      rst = v.rst; busy = v.busy; wake_req = v.wake; force_on = v.frc; stop_ack = v.ack;
      @(posedge clk);
      #1;
      act = {stop_req, en, gated, wake_done};
      n_vec++;
      if (act !== v.exp) begin
         n_err++;
         $display("FAIL %s: got req/en/gated/done=%b want %b", v.name, act, v.exp);
      end
   endtask

   initial begin
      rst = 1'b1; busy = 1'b1; wake_req = 1'b0; force_on = 1'b0; stop_ack = 1'b0;

      //   rst busy wake frc ack  exp
      add(1, 1, 0, 0, 0, 4'b0100, "reset0");
      add(1, 1, 0, 0, 0, 4'b0100, "reset1");
      // full gate cycle: idle 4 counts, STOP_REQ rises on 5th edge
      add(0, 0, 0, 0, 0, 4'b0100, "idle1");
      add(0, 0, 0, 0, 0, 4'b0100, "idle2");
      add(0, 0, 0, 0, 0, 4'b0100, "idle3");
      add(0, 0, 0, 0, 0, 4'b0100, "idle4");
      add(0, 0, 0, 0, 0, 4'b1100, "stop_req_rise");
      add(0, 0, 0, 0, 1, 4'b1010, "gate_on_ack");
      add(0, 1, 0, 0, 0, 4'b1010, "gated_ignores_busy_ackdrop");
      add(0, 0, 1, 0, 0, 4'b1100, "wake_en_up");
      add(0, 1, 0, 0, 0, 4'b1100, "wake_settle_no_abort");
      add(0, 1, 0, 0, 0, 4'b0101, "wake_done_pulse");
      add(0, 1, 0, 0, 0, 4'b0100, "wake_done_clears");
      // idle abort at idle cycle 3, then a full fresh count
      add(0, 0, 0, 0, 1, 4'b0100, "abort_idle1_ack_ignored");
      add(0, 0, 0, 0, 0, 4'b0100, "abort_idle2");
      add(0, 0, 0, 0, 0, 4'b0100, "abort_idle3");
      add(0, 1, 0, 0, 0, 4'b0100, "abort_busy");
      add(0, 0, 0, 0, 0, 4'b0100, "recount1");
      add(0, 0, 0, 0, 0, 4'b0100, "recount2");
      add(0, 0, 0, 0, 0, 4'b0100, "recount3");
      add(0, 0, 0, 0, 0, 4'b0100, "recount4");
      add(0, 0, 0, 0, 0, 4'b1100, "recount_stop_req");
      // race: ack and force-on together in STOP_REQ
      add(0, 0, 0, 1, 1, 4'b0100, "race_force_wins");
      add(0, 0, 0, 1, 0, 4'b0100, "race_stay_run");
      // busy aborts STOP_REQ too
      add(0, 0, 0, 0, 0, 4'b0100, "b_idle1");
      add(0, 0, 0, 0, 0, 4'b0100, "b_idle2");
      add(0, 0, 0, 0, 0, 4'b0100, "b_idle3");
      add(0, 0, 0, 0, 0, 4'b0100, "b_idle4");
      add(0, 0, 0, 0, 0, 4'b1100, "b_stop_req");
      add(0, 1, 0, 0, 1, 4'b0100, "busy_beats_ack");
      // reset mid-gate
      add(0, 0, 0, 0, 0, 4'b0100, "r_idle1");
      add(0, 0, 0, 0, 0, 4'b0100, "r_idle2");
      add(0, 0, 0, 0, 0, 4'b0100, "r_idle3");
      add(0, 0, 0, 0, 0, 4'b0100, "r_idle4");
      add(0, 0, 0, 0, 0, 4'b1100, "r_stop_req");
      add(0, 0, 0, 0, 1, 4'b1010, "r_gated");
      add(0, 0, 0, 0, 1, 4'b1010, "r_gated_hold");
      add(1, 0, 0, 0, 1, 4'b0100, "reset_mid_gate");
      add(0, 1, 0, 0, 0, 4'b0100, "post_reset_run");

      foreach (tbl[i]) apply(tbl[i]);

      // Force-on wake from GATED, wake request low throughout
      for (int i = 0; i < 4; i++) apply('{0, 0, 0, 0, 0, 4'b0100, "f_idle"});
      apply('{0, 0, 0, 0, 0, 4'b1100, "f_stop_req"});
      apply('{0, 0, 0, 0, 1, 4'b1010, "f_gated"});
      apply('{0, 0, 0, 1, 0, 4'b1100, "f_force_wake"});
      apply('{0, 0, 0, 0, 0, 4'b1100, "f_settle"});
      apply('{0, 0, 0, 0, 0, 4'b0101, "f_done"});
      apply('{0, 0, 0, 1, 0, 4'b0100, "f_run"});

      // Hold force-on with no activity: clock never stops
      for (int i = 0; i < 100; i++) apply('{0, 0, 0, 1, 0, 4'b0100, "hold_force"});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
